// File: rtl/radio_uplink_tx.sv
// rtl/radio_uplink_tx.sv - FIFO-fed 14-bit word serialiser for the four-wire radio uplink
// Optional corrupt-frame injection on the final dibit: RADIO_UPLINK_ERRINJ_EN
`timescale 1ns/1ps
module radio_uplink_tx #(
    parameter int PHASE_CYCLES = 8,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        done,
    output logic        RPULSE,
    output logic        RD1,
    output logic        RD0,
    output logic        RCHECK
);
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam int CW         = $clog2(PHASE_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_PULSE = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [14:0]      mem_q [FIFO_DEPTH];
    logic [14:0]      mem_d [FIFO_DEPTH];
    logic [14:0]      head;
    logic             push, pop;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [13:0]   sr_q, sr_d;
    logic [2:0]    n_q, n_d;
    logic          corrupt_q, corrupt_d;
    logic          done_q, done_d;
    logic          rpulse_q, rpulse_d, rd1_q, rd1_d, rd0_q, rd0_d, rcheck_q, rcheck_d;
    logic          phase_last, inject;
    logic          unused_wr_msb;

    assign unused_wr_msb = wr_data[15];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign push  = wr_en && !full;
    assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign phase_last = (cnt_q == CW'(PHASE_CYCLES - 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = wr_data[14:0];
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        n_d       = n_q;
        corrupt_d = corrupt_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        cnt_d     = '0;
        if (state_q != S_IDLE && !phase_last)
            cnt_d = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sr_d      = head[13:0];
                    corrupt_d = head[14];
                    n_d       = 3'd0;
                    state_d   = S_SYNC;
                end
            end
            S_SYNC:  if (phase_last) state_d = S_GAP;
            S_GAP:   if (phase_last) state_d = S_SETUP;
            S_SETUP: if (phase_last) state_d = S_PULSE;
            S_PULSE: begin
                if (phase_last) begin
                    sr_d = {sr_q[11:0], 2'b00};
                    if (n_q == 3'd6) begin
                        state_d = S_END;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_END: begin
                if (phase_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef RADIO_UPLINK_ERRINJ_EN
    assign inject = corrupt_d && (n_d == 3'd6);
`else
    assign inject = 1'b0;
`endif

    // Outputs are decoded from next-state values so the pins change on the same edge as the state.
    always_comb begin
        rpulse_d = 1'b0;
        rd1_d    = 1'b0;
        rd0_d    = 1'b0;
        rcheck_d = 1'b0;
        case (state_d)
            S_SYNC: begin
                rpulse_d = 1'b1;
                rd1_d    = 1'b1;
                rd0_d    = 1'b1;
                rcheck_d = 1'b1;
            end
            S_SETUP, S_PULSE: begin
                rpulse_d = (state_d == S_PULSE);
                rd1_d    = sr_d[13];
                rd0_d    = sr_d[12];
                rcheck_d = sr_d[13] ^ sr_d[12] ^ inject;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            n_q       <= '0;
            corrupt_q <= 1'b0;
            done_q    <= 1'b0;
            rpulse_q  <= 1'b0;
            rd1_q     <= 1'b0;
            rd0_q     <= 1'b0;
            rcheck_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            n_q       <= n_d;
            corrupt_q <= corrupt_d;
            done_q    <= done_d;
            rpulse_q  <= rpulse_d;
            rd1_q     <= rd1_d;
            rd0_q     <= rd0_d;
            rcheck_q  <= rcheck_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign RPULSE = rpulse_q;
    assign RD1    = rd1_q;
    assign RD0    = rd0_q;
    assign RCHECK = rcheck_q;
endmodule

// File: tb/tb_radio_uplink_tx.sv
// tb/tb_radio_uplink_tx.sv - self-checking bench for radio_uplink_tx with receiver model and scoreboard
`timescale 1ns/1ps
module tb_radio_uplink_tx;
    localparam int PC = 8;
`ifdef RADIO_UPLINK_ERRINJ_EN
    localparam bit ERRV = 1'b0;
`else
    localparam bit ERRV = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        full, empty, busy, done, RPULSE, RD1, RD0, RCHECK;

    always #5 clk = ~clk;

    radio_uplink_tx #(.PHASE_CYCLES(PC), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .busy(busy), .done(done),
        .RPULSE(RPULSE), .RD1(RD1), .RD0(RD0), .RCHECK(RCHECK)
    );

    typedef struct packed {
        logic [13:0] word;
        logic        valid;
    } exp_t;

    typedef struct {
        logic [15:0] wdata;
        logic [13:0] exp_word;
        logic        exp_valid;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frames_rx = 0;
    int   done_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver model: resync on all-ones strobe, then capture seven dibits on RPULSE rises.
    logic        prev_rp = 1'b0;
    logic        rx_active = 1'b0;
    logic        rx_ok = 1'b1;
    logic [13:0] rx_w = '0;
    int          rx_n = 0;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            prev_rp   = 1'b0;
            rx_active = 1'b0;
            rx_n      = 0;
        end else begin
            if (done) done_cnt++;
            if (RPULSE && !prev_rp) begin
                if (RD1 && RD0 && RCHECK) begin
                    rx_active = 1'b1;
                    rx_n = 0;
                    rx_ok = 1'b1;
                    rx_w = '0;
                end else if (rx_active) begin
                    rx_w = {rx_w[11:0], RD1, RD0};
                    if (RCHECK !== (RD1 ^ RD0)) rx_ok = 1'b0;
                    rx_n++;
                    if (rx_n == 7) begin
                        rx_active = 1'b0;
                        frames_rx++;
                        if (sb_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_unexpected_frame: got word %0h, none expected", rx_w);
                        end else begin
                            e = sb_q.pop_front();
                            check("rx_word", rx_w, e.word);
                            check("rx_valid", rx_ok, e.valid);
                        end
                    end
                end
            end
            prev_rp = RPULSE;
        end
    end

    task automatic push(input logic [15:0] d, input exp_t ex, input bit track);
        wr_en = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (track) sb_q.push_back(ex);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, done, 1);
    endtask

    task automatic wave_frame(input logic [13:0] w, input string name);
        int errs = 0, alias_cnt = 0, ph, i;
        logic [3:0] exp_o, act_o;
        logic [1:0] dib;
        push({2'b00, w}, '{word: w, valid: 1'b1}, 1'b1);
        check({name, "_empty_t1"}, empty, 0);
        check({name, "_busy_t1"}, busy, 0);
        for (int c = 0; c < 17 * PC; c++) begin
            @(posedge clk);
            #1;
            ph = c / PC;
            if (ph == 0) exp_o = 4'b1111;
            else if (ph >= 2 && ph <= 15) begin
                i = (ph - 2) / 2;
                dib = w[13 - 2 * i -: 2];
                exp_o = {1'(((ph - 2) % 2)), dib, dib[1] ^ dib[0]};
            end else exp_o = 4'b0000;
            act_o = {RPULSE, RD1, RD0, RCHECK};
            if (act_o !== exp_o || busy !== 1'b1 || done !== 1'b0) begin
                if (errs < 4) $display("  %s cycle %0d: pins %b want %b busy %b done %b", name, c, act_o, exp_o, busy, done);
                errs++;
            end
            if (ph >= 1 && act_o == 4'b1111) alias_cnt++;
        end
        check({name, "_waveform_errs"}, errs, 0);
        check({name, "_sync_alias"}, alias_cnt, 0);
        @(posedge clk);
        #1;
        check({name, "_done_at_136"}, done, 1);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    vec_t vecs[6];
    int   f0, d0, k, rises, fr;
    logic prev_s;

    initial begin
        vecs[0] = '{16'h2D3A, 14'h2D3A, 1'b1};
        vecs[1] = '{16'h0000, 14'h0000, 1'b1};
        vecs[2] = '{16'h1555, 14'h1555, 1'b1};
        vecs[3] = '{16'h2AAA, 14'h2AAA, 1'b1};
        vecs[4] = '{16'h8123, 14'h0123, 1'b1};
        vecs[5] = '{16'h4001, 14'h0001, ERRV};

        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pins", {RPULSE, RD1, RD0, RCHECK}, 4'b0000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        wave_frame(14'h2D3A, "w2d3a");
        wave_frame(14'h3FFF, "w3fff");
        check("wave_frames_rx", frames_rx, 2);
        check("wave_sb_drained", sb_q.size(), 0);

        for (int v = 0; v < 6; v++) begin
            f0 = frames_rx;
            push(vecs[v].wdata, '{word: vecs[v].exp_word, valid: vecs[v].exp_valid}, 1'b1);
            wait_done(20 * PC + 20, "vec_done_timeout");
            check("vec_frame_count", frames_rx, f0 + 1);
            @(posedge clk);
            #1;
        end

        f0 = frames_rx;
        d0 = done_cnt;
        for (int v = 0; v < 5; v++) begin
            push(16'h0100 + 16'(v * 16'h0111), '{word: 14'(16'h0100 + v * 16'h0111), valid: 1'b1}, 1'b1);
            if (v == 3) check("b2b_not_full_at_3", full, 0);
        end
        check("b2b_full", full, 1);
        push(16'h3ABC, '{word: 14'h3ABC, valid: 1'b1}, 1'b0);
        check("b2b_full_after_drop", full, 1);
        k = 0;
        while (frames_rx < f0 + 5 && k < 5 * 17 * PC + 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (200) @(posedge clk);
        #1;
        check("b2b_frames", frames_rx, f0 + 5);
        check("b2b_dones", done_cnt, d0 + 5);
        check("b2b_sb_drained", sb_q.size(), 0);
        check("b2b_empty", empty, 1);

        push(16'h1234, '{word: 14'h1234, valid: 1'b1}, 1'b1);
        push(16'h0F0F, '{word: 14'h0F0F, valid: 1'b1}, 1'b1);
        rises = 0;
        prev_s = RPULSE;
        k = 0;
        while (rises < 5 && k < 400) begin
            @(posedge clk);
            #1;
            if (RPULSE && !prev_s) rises++;
            prev_s = RPULSE;
            k++;
        end
        check("rst_reach_4th_pulse", rises, 5);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pins", {RPULSE, RD1, RD0, RCHECK}, 4'b0000);
        check("midrst_busy", busy, 0);
        check("midrst_empty", empty, 1);
        check("midrst_full", full, 0);
        sb_q.delete();
        fr = frames_rx;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(16'h2C5D, '{word: 14'h2C5D, valid: 1'b1}, 1'b1);
        wait_done(20 * PC + 20, "postrst_done_timeout");
        check("postrst_frames", frames_rx, fr + 1);
        check("postrst_sb_drained", sb_q.size(), 0);
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
